// File: rtl/pad_input_conditioner.sv
// Multi-channel conditioner for asynchronous pad inputs: synchroniser, glitch
// filter with per-channel bypass, edge strobes and saturating glitch counters.
module pad_input_conditioner #(
  parameter int            CH          = 4,
  parameter int            SYNC_STAGES = 2,
  parameter int            FILT_LEN    = 4,
  parameter logic [CH-1:0] RST_VAL     = {CH{1'b0}}
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic [CH-1:0]   i_IN,
  input  logic [CH-1:0]   i_FILT_EN,
  input  logic            i_GLITCH_CLR,
  output logic [CH-1:0]   o_OUT,
  output logic [CH-1:0]   o_RISE,
  output logic [CH-1:0]   o_FALL,
  output logic [CH-1:0]   o_GLITCH,
  output logic [8*CH-1:0] o_GLITCH_CNT
);
  localparam int            CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CH-1:0] sync_r [SYNC_STAGES];
  logic [CH-1:0] sync_s;
  logic [CW-1:0] cnt_r  [CH];
  logic [CW-1:0] cnt_s  [CH];
  logic [7:0]    gcnt_r [CH];
  logic [7:0]    gcnt_s [CH];
  logic [CH-1:0] out_r;
  logic [CH-1:0] out_s;
  logic [CH-1:0] glitch_s;

  // Synchroniser chain; the last stage feeds the filter.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= RST_VAL;
    end else begin
      sync_r[0] <= i_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Per-channel filter and glitch-counter next state.
  always_comb begin
    out_s    = out_r;
    glitch_s = {CH{1'b0}};
    for (int n = 0; n < CH; n++) begin
      cnt_s[n] = {CW{1'b0}};
      if (!i_FILT_EN[n]) begin
        out_s[n] = sync_s[n];
      end else if (sync_s[n] == out_r[n]) begin
        glitch_s[n] = (cnt_r[n] != {CW{1'b0}});
      end else if (cnt_r[n] == CNT_LAST) begin
        out_s[n] = sync_s[n];
      end else begin
        cnt_s[n] = cnt_r[n] + CW'(1'b1);
      end

      // Clear beats a coincident glitch; the count holds once saturated.
      if (i_GLITCH_CLR) begin
        gcnt_s[n] = 8'd0;
      end else if (glitch_s[n] && (gcnt_r[n] != 8'hFF)) begin
        gcnt_s[n] = gcnt_r[n] + 8'd1;
      end else begin
        gcnt_s[n] = gcnt_r[n];
      end
    end
  end

  // Filter state, conditioned level, strobes and counters.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      out_r    <= RST_VAL;
      o_RISE   <= {CH{1'b0}};
      o_FALL   <= {CH{1'b0}};
      o_GLITCH <= {CH{1'b0}};
      for (int n = 0; n < CH; n++) begin
        cnt_r[n]  <= {CW{1'b0}};
        gcnt_r[n] <= 8'd0;
      end
    end else begin
      out_r    <= out_s;
      o_RISE   <= out_s & ~out_r;
      o_FALL   <= ~out_s & out_r;
      o_GLITCH <= glitch_s;
      for (int n = 0; n < CH; n++) begin
        cnt_r[n]  <= cnt_s[n];
        gcnt_r[n] <= gcnt_s[n];
      end
    end
  end

  assign o_OUT = out_r;

  for (genvar g = 0; g < CH; g++) begin : g_cnt_pack
    assign o_GLITCH_CNT[8*g +: 8] = gcnt_r[g];
  end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed and randomised checks of pad_input_conditioner across four
// parameterisations, with a window-based reference model for the random phase.
module tb_pad_input_conditioner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default configuration, reset level 0
  logic [3:0]  in_a, en_a, out_a, rise_a, fall_a, glt_a;
  logic        clr_a;
  logic [31:0] cnt_a;
  // Default configuration, reset level 4'b0101
  logic [3:0]  in_b, en_b, out_b, rise_b, fall_b, glt_b;
  logic [31:0] cnt_b;
  // CH=8, SYNC_STAGES=3, FILT_LEN=1 (c) and 16 (d), shared random stimulus
  logic [7:0]  in_r, en_r, out_c, rise_c, fall_c, glt_c, out_d, rise_d, fall_d, glt_d;
  logic        clr_r;
  logic [63:0] cnt_c, cnt_d;

  pad_input_conditioner #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .RST_VAL(4'b0000)) dut_a (
    .i_CLK(clk), .i_RST(rst), .i_IN(in_a), .i_FILT_EN(en_a), .i_GLITCH_CLR(clr_a),
    .o_OUT(out_a), .o_RISE(rise_a), .o_FALL(fall_a), .o_GLITCH(glt_a), .o_GLITCH_CNT(cnt_a));
  pad_input_conditioner #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .RST_VAL(4'b0101)) dut_b (
    .i_CLK(clk), .i_RST(rst), .i_IN(in_b), .i_FILT_EN(en_b), .i_GLITCH_CLR(1'b0),
    .o_OUT(out_b), .o_RISE(rise_b), .o_FALL(fall_b), .o_GLITCH(glt_b), .o_GLITCH_CNT(cnt_b));
  pad_input_conditioner #(.CH(8), .SYNC_STAGES(3), .FILT_LEN(1), .RST_VAL(8'h00)) dut_c (
    .i_CLK(clk), .i_RST(rst), .i_IN(in_r), .i_FILT_EN(en_r), .i_GLITCH_CLR(clr_r),
    .o_OUT(out_c), .o_RISE(rise_c), .o_FALL(fall_c), .o_GLITCH(glt_c), .o_GLITCH_CNT(cnt_c));
  pad_input_conditioner #(.CH(8), .SYNC_STAGES(3), .FILT_LEN(16), .RST_VAL(8'h00)) dut_d (
    .i_CLK(clk), .i_RST(rst), .i_IN(in_r), .i_FILT_EN(en_r), .i_GLITCH_CLR(clr_r),
    .o_OUT(out_d), .o_RISE(rise_d), .o_FALL(fall_d), .o_GLITCH(glt_d), .o_GLITCH_CNT(cnt_d));

  // Reference state for the random phase
  logic [7:0]  in_q[$];
  logic [7:0]  s_hist[$];
  logic [7:0]  m_out1, m_out16, m_r, m_f, m_g1, m_g16, s_now;
  logic [63:0] m_cnt1, m_cnt16;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // A level is accepted once the last fl synchronised samples all differ from
  // the output; a glitch is a return to the output level right after a sample
  // that differed from it.
  task automatic model_step(input int fl, input logic [7:0] cur, output logic [7:0] nout,
                            output logic [7:0] r, output logic [7:0] f, output logic [7:0] g);
    bit all_diff;
    nout = cur;
    r = 8'h00;
    f = 8'h00;
    g = 8'h00;
    for (int n = 0; n < 8; n++) begin
      all_diff = 1'b1;
      for (int j = 0; j < fl; j++) if (s_hist[15-j][n] == cur[n]) all_diff = 1'b0;
      if (all_diff) begin
        nout[n] = s_hist[15][n];
        r[n]    = s_hist[15][n];
        f[n]    = ~s_hist[15][n];
      end
      g[n] = (s_hist[15][n] == cur[n]) && (s_hist[14][n] != cur[n]);
    end
  endtask

  function automatic logic [63:0] cnt_next(input logic [63:0] c, input logic [7:0] g, input bit clr);
    logic [63:0] res;
    res = c;
    for (int n = 0; n < 8; n++) begin
      if (clr) res[8*n +: 8] = 8'd0;
      else if (g[n] && c[8*n +: 8] != 8'hFF) res[8*n +: 8] = c[8*n +: 8] + 8'd1;
    end
    return res;
  endfunction

  initial begin
    rst = 1'b1; in_a = 4'h0; en_a = 4'hF; clr_a = 1'b0;
    in_b = 4'b0101; en_b = 4'hF; in_r = 8'h00; en_r = 8'hFF; clr_r = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_b_out", out_b, 4'b0101);
    check("rst_b_strobes", {rise_b, fall_b, glt_b}, 12'h000);
    check("rst_b_cnt", cnt_b, 32'h0);
    check("rst_a_out", out_a, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("rel_b_rise", rise_b, 4'h0);
      check("rel_b_out", out_b, 4'b0101);
    end

    // Filtered latency on ch0: rise after edge 6
    in_a[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("lat_out", out_a[0], (k >= 6));
      check("lat_rise", rise_a[0], (k == 6));
    end

    // Bypass latency on ch0: fall after edge 3
    en_a[0] = 1'b0; in_a[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("byp_out", out_a[0], (k < 3));
      check("byp_fall", fall_a[0], (k == 3));
    end
    en_a[0] = 1'b1;

    // 3-cycle pulse on ch1 is rejected as one glitch
    in_a[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) in_a[1] = 1'b0;
      check("rej_out", out_a[1], 1'b0);
      check("rej_glitch", glt_a[1], (k == 6));
    end
    check("rej_cnt", cnt_a[15:8], 8'd1);

    // 4-cycle pulse on ch1 is accepted
    in_a[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) in_a[1] = 1'b0;
      check("acc_out", out_a[1], (k >= 6 && k < 10));
      check("acc_rise", rise_a[1], (k == 6));
      check("acc_fall", fall_a[1], (k == 10));
      check("acc_glitch", glt_a[1], 1'b0);
    end
    check("acc_cnt", cnt_a[15:8], 8'd1);

    // 300 single-cycle pulses on ch2 saturate the counter
    for (int p = 0; p < 300; p++) begin
      in_a[2] = 1'b1;
      tick();
      in_a[2] = 1'b0;
      tick(); tick(); tick();
      check("sat_glitch", glt_a[2], 1'b1);
    end
    check("sat_cnt", cnt_a[23:16], 8'd255);
    check("sat_out", out_a[2], 1'b0);

    // Clear coincident with a glitch
    in_a[2] = 1'b1;
    tick();
    in_a[2] = 1'b0;
    tick(); tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr_glitch", glt_a[2], 1'b1);
    check("clr_cnt", cnt_a, 32'h0);

    // Bypass selected on ch3 with cnt=2: no glitch, output follows s
    in_a[3] = 1'b1;
    repeat (4) tick();
    en_a[3] = 1'b0;
    tick();
    check("mode_out", out_a[3], 1'b1);
    check("mode_rise", rise_a[3], 1'b1);
    check("mode_glitch", glt_a[3], 1'b0);
    // Re-enable: counting restarts from 0
    en_a[3] = 1'b1; in_a[3] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("resume_out", out_a[3], (k < 6));
      check("resume_fall", fall_a[3], (k == 6));
      check("resume_glitch", glt_a[3], 1'b0);
    end
    check("mode_cnt", cnt_a[31:24], 8'd0);

    // Reset mid-filter on ch0 discards the pending count
    in_a[0] = 1'b1;
    repeat (4) tick();
    rst = 1'b1; in_a[0] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("rstmid_glitch", glt_a, 4'h0);
      check("rstmid_out", out_a, 4'h0);
    end
    check("rstmid_cnt", cnt_a, 32'h0);

    // Random phase: reference state right after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) in_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) s_hist.push_back(8'h00);
    m_out1 = 8'h00; m_out16 = 8'h00; m_cnt1 = 64'h0; m_cnt16 = 64'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int n = 0; n < 8; n++) if ($urandom_range(9) == 0) in_r[n] = ~in_r[n];
      clr_r = ($urandom_range(99) == 0);
      tick();
      s_now = in_q.pop_front();
      in_q.push_back(in_r);
      s_hist.push_back(s_now);
      void'(s_hist.pop_front());
      model_step(1, m_out1, m_out1, m_r, m_f, m_g1);
      m_cnt1 = cnt_next(m_cnt1, m_g1, clr_r);
      check("rnd1_out", out_c, m_out1);
      check("rnd1_rise", rise_c, m_r);
      check("rnd1_fall", fall_c, m_f);
      check("rnd1_glitch", glt_c, m_g1);
      check("rnd1_cnt", cnt_c, m_cnt1);
      model_step(16, m_out16, m_out16, m_r, m_f, m_g16);
      m_cnt16 = cnt_next(m_cnt16, m_g16, clr_r);
      check("rnd16_out", out_d, m_out16);
      check("rnd16_rise", rise_d, m_r);
      check("rnd16_fall", fall_d, m_f);
      check("rnd16_glitch", glt_d, m_g16);
      check("rnd16_cnt", cnt_d, m_cnt16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pad_input_conditioner.md
# pad_input_conditioner

Parametrised multi-channel conditioner for asynchronous pad inputs such as ADS1292_DRDY, ADS1292_MISO, UART_RXD and the I2C SCL/SDA receive paths. It sits between the input pad cells and khu_sensor_top. Per channel it provides:
- an N-stage synchroniser;
- a programmable-length glitch filter with per-channel bypass;
- single-cycle rise/fall strobes;
- a saturating glitch counter for board bring-up diagnostics.

It generalises the single-bit reset glitch synchroniser to CH independent channels with configurable depth and observable rejection statistics.

## Interface
Parameters:
- CH, 4: number of independent channels (1..32)
- SYNC_STAGES, 2: synchroniser flops per channel (2..4)
- FILT_LEN, 4: consecutive synchronised cycles a new level must persist before acceptance (1..16)
- RST_VAL, {CH{1'b0}}: per-channel reset level of synchroniser flops and o_OUT

Ports:
- i_CLK  input  1  single system clock; all logic on its rising edge
- i_RST  input  1  synchronous, active-high reset
- i_IN  input  CH  asynchronous pad inputs, bit n = channel n
- i_FILT_EN  input  CH  1 = filter active on channel n, 0 = bypass (synchroniser only)
- i_GLITCH_CLR  input  1  synchronous clear of all glitch counters
- o_OUT  output  CH  conditioned level
- o_RISE  output  CH  one-cycle strobe, o_OUT 0->1
- o_FALL  output  CH  one-cycle strobe, o_OUT 1->0
- o_GLITCH  output  CH  one-cycle strobe, pending transition aborted
- o_GLITCH_CNT  output  8*CH  saturating glitch count, channel n in bits [8n+7:8n]

## Operation
- Synchroniser: sync[0] samples i_IN each edge and feeds sync[SYNC_STAGES-1]. s denotes the last synchroniser stage.
- Each channel has a filter counter cnt, width $clog2(FILT_LEN) (minimum 1 bit).
- Filter active, s == o_OUT:
  - cnt <= 0.
  - If cnt != 0, a glitch occurred: o_GLITCH pulses and the count increments, saturating at 255.
- Filter active, s != o_OUT:
  - If cnt == FILT_LEN-1: o_OUT <= s and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Bypass (i_FILT_EN[n]=0): o_OUT <= s every edge, cnt forced to 0. No glitch is recorded, including a pending count discarded at the moment bypass is selected.
- Leaving bypass: filtering resumes from cnt=0 against the current o_OUT.
- o_RISE/o_FALL are registered and assert in the same cycle o_OUT takes its new value. They are never asserted together on one channel.
- i_GLITCH_CLR:
  - Counters become 0 on the next edge.
  - If a glitch occurs in the same cycle, clear wins (count = 0) but o_GLITCH still pulses.
- Channels are fully independent; there are no shared state machines.

## Timing
- Reset (i_RST=1 at an edge), all outputs valid after that edge:
  - sync flops and o_OUT = RST_VAL
  - cnt = 0
  - o_RISE = o_FALL = o_GLITCH = 0
  - o_GLITCH_CNT = 0
- No edge strobe is generated for the reset value, or on the first cycle after reset release.
- Reset mid-filter: the pending count is discarded and no glitch is counted.
- Latency (first sampling edge counts as edge 1):
  - A level held stable appears on o_OUT after edge SYNC_STAGES+FILT_LEN (default 6).
  - In bypass, it appears after edge SYNC_STAGES+1 (default 3).
  - FILT_LEN=1 is identical to bypass, but counting no glitches.
- Rejection: a synchronised pulse of FILT_LEN-1 cycles or shorter is rejected and counted as one glitch. A pulse of exactly FILT_LEN cycles is accepted.
- Minimum accepted pulse on the pad: FILT_LEN clock periods (asynchronous sampling uncertainty ±1 cycle).
- Strobes and o_GLITCH are exactly one cycle wide.
- Counter saturation: at 255, further glitches still pulse o_GLITCH but the count holds.
- Outputs are pure register outputs; there is no combinational path from i_IN.

## Test plan
- Reset: RST_VAL=4'b0101, assert i_RST 3 cycles -> o_OUT=4'b0101, all strobes 0, counts 0; no o_RISE after release with i_IN=4'b0101.
- Latency: defaults, ch0 0->1 held -> o_OUT[0] rises after edge 6 with o_RISE[0] for one cycle; same in bypass -> after edge 3.
- Glitch rejection: ch1 pulse of 3 cycles (FILT_LEN=4) -> o_OUT[1] unchanged, o_GLITCH[1] one cycle, count[1]=1; a 4-cycle pulse -> accepted, o_RISE then o_FALL.
- Saturation/clear: 300 short pulses on ch2 -> count=255, o_GLITCH still pulses; i_GLITCH_CLR coincident with a glitch -> count=0.
- Mode switch: ch3 mid-count (cnt=2) set i_FILT_EN[3]=0 -> no glitch, o_OUT follows s next edge; re-enable -> filtering resumes from cnt 0.
- Independence: random asynchronous toggling on all channels vs. reference model, CH=8, SYNC_STAGES=3, FILT_LEN=1 and 16 -> outputs, strobes and counts match cycle-exactly.
